// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: forwarding-select, load-use/RAW stall and branch-flush control
// for a 5-stage pipeline, plus a saturating hazard-stall counter.
module pipe_hazard_unit #(
    parameter int RW     = 5,
    parameter int FWD_EN = 1,
    parameter int CW     = 16
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rt,
    input  logic          use_rs,
    input  logic          use_rt,
    input  logic          exe_wreg,
    input  logic          exe_m2reg,
    input  logic [RW-1:0] exe_rd,
    input  logic          mem_wreg,
    input  logic          mem_m2reg,
    input  logic [RW-1:0] mem_rd,
    input  logic          mem_busy,
    input  logic          branch_taken,
    input  logic          clr_cnt,
    output logic [1:0]    fwda,
    output logic [1:0]    fwdb,
    output logic          pc_en,
    output logic          id_bubble,
    output logic          flush_id,
    output logic          freeze,
    output logic [CW-1:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, FREEZE, FLUSH} state_t;

    state_t        state_q;
    logic          pend_br_q;
    logic          flush_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_ea, hit_eb, hit_ma, hit_mb;
    logic          hz_stall, br_acc;

    // Register 0 is hard-wired zero, so it never produces a dependency.
    assign hit_ea = use_rs & exe_wreg & (exe_rd != '0) & (exe_rd == rs);
    assign hit_eb = use_rt & exe_wreg & (exe_rd != '0) & (exe_rd == rt);
    assign hit_ma = use_rs & mem_wreg & (mem_rd != '0) & (mem_rd == rs);
    assign hit_mb = use_rt & mem_wreg & (mem_rd != '0) & (mem_rd == rt);

    function automatic logic [1:0] fsel(input logic he, input logic hm);
        return (he & ~exe_m2reg) ? 2'b01 : hm ? (mem_m2reg ? 2'b11 : 2'b10) : 2'b00;
    endfunction

    assign fwda      = (FWD_EN != 0) ? fsel(hit_ea, hit_ma) : 2'b00;
    assign fwdb      = (FWD_EN != 0) ? fsel(hit_eb, hit_mb) : 2'b00;
    assign hz_stall  = (FWD_EN != 0) ? ((hit_ea | hit_eb) & exe_m2reg)
                                     : (hit_ea | hit_eb | hit_ma | hit_mb);
    assign freeze    = mem_busy;
    assign pc_en     = ~(freeze | hz_stall);
    assign id_bubble = hz_stall & ~freeze;
    assign br_acc    = branch_taken & ~hz_stall;
    assign flush_id  = flush_q;
    assign stall_cnt = cnt_q;

    assign cnt_d = clr_cnt ? '0 : (id_bubble & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q   <= RUN;
            pend_br_q <= 1'b0;
            flush_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        state_q   <= FREEZE;
                        pend_br_q <= br_acc;
                    end else if (br_acc) begin
                        state_q <= FLUSH;
                        flush_q <= 1'b1;
                    end
                end
                FREEZE: begin
                    if (mem_busy) begin
                        pend_br_q <= pend_br_q | br_acc;
                    end else begin
                        state_q   <= (pend_br_q | br_acc) ? FLUSH : RUN;
                        flush_q   <= pend_br_q | br_acc;
                        pend_br_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    // The slot being squashed cannot redirect again.
                    state_q <= mem_busy ? FREEZE : RUN;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q   <= RUN;
                    pend_br_q <= 1'b0;
                    flush_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter RW, default 5, register-index width.
REQ-002 SHALL have parameter FWD_EN, default 1; 1 = forwarding mode, 0 = stall-only mode with no forwarding.
REQ-003 SHALL have parameter CW, default 16, stall-counter width.
REQ-004 SHALL use one clock and an asynchronous active-low reset: Clk  in  1  rising-edge clock.
REQ-005 Clrn  in  1  asynchronous active-low reset.
REQ-006 rs  in  RW  ID-stage source register A.
REQ-007 rt  in  RW  ID-stage source register B.
REQ-008 use_rs  in  1  ID instruction reads rs (0 when ID holds no valid instruction).
REQ-009 use_rt  in  1  ID instruction reads rt (0 when ID holds no valid instruction).
REQ-010 exe_wreg  in  1  EXE instruction writes the register file.
REQ-011 exe_m2reg  in  1  EXE instruction is a load.
REQ-012 exe_rd  in  RW  EXE destination register.
REQ-013 mem_wreg  in  1  MEM instruction writes the register file.
REQ-014 mem_m2reg  in  1  MEM instruction is a load.
REQ-015 mem_rd  in  RW  MEM destination register.
REQ-016 mem_busy  in  1  data memory not ready; the whole pipeline must hold.
REQ-017 branch_taken  in  1  ID-resolved branch or jump redirects PC this cycle.
REQ-018 clr_cnt  in  1  synchronous clear of stall_cnt.
REQ-019 fwda  out  2  operand A select: 00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load data.
REQ-020 fwdb  out  2  operand B select, same encoding as fwda.
REQ-021 pc_en  out  1  PC and IF/ID register write enable.
REQ-022 id_bubble  out  1  load a NOP into ID/EX.
REQ-023 flush_id  out  1  squash the IF/ID contents.
REQ-024 freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-025 stall_cnt  out  CW  count of hazard-stall cycles.

Function
REQ-026 A match on register index 0 SHALL never create a hazard or a forward.
REQ-027 hitE SHALL be defined as exe_wreg & exe_rd!=0 & exe_rd==src; hitM SHALL be defined as mem_wreg & mem_rd!=0 & mem_rd==src; each is evaluated per source, qualified by that source's use_* flag.
REQ-028 FWD_EN=1: fwdX SHALL be 01 if hitE & ~exe_m2reg, else 10 if hitM & ~mem_m2reg, else 11 if hitM & mem_m2reg, else 00 (EXE has priority over MEM).
REQ-029 FWD_EN=1: hz_stall SHALL be 1 exactly when hitE & exe_m2reg holds for rs or rt (load-use).
REQ-030 FWD_EN=0: fwda and fwdb SHALL be constant 00, and hz_stall SHALL be 1 whenever hitE or hitM holds for rs or rt.
REQ-031 freeze SHALL equal mem_busy, combinationally.
REQ-032 pc_en SHALL equal ~(freeze | hz_stall); id_bubble SHALL equal hz_stall & ~freeze.
REQ-033 The FSM SHALL have states RUN, FREEZE and FLUSH; flush_id SHALL be 1 only in FLUSH.
REQ-034 A branch SHALL be accepted only when branch_taken & ~hz_stall.
REQ-035 RUN: mem_busy SHALL take the FSM to FREEZE, setting pend_br if a branch is accepted in the same cycle; otherwise an accepted branch SHALL take it to FLUSH; otherwise it stays in RUN.
REQ-036 FREEZE: an accepted branch SHALL set pend_br; on mem_busy=0 the FSM SHALL go to FLUSH if pend_br or a branch is accepted this cycle (clearing pend_br), else to RUN.
REQ-037 FLUSH: the FSM SHALL stay exactly one cycle and branch_taken SHALL be ignored (the squashed slot); next state SHALL be FREEZE if mem_busy, else RUN.
REQ-038 stall_cnt SHALL increment on cycles with id_bubble=1, saturate at all-ones, and clear_cnt SHALL win over increment.

Reset
REQ-039 Clrn=0 SHALL asynchronously force state RUN, pend_br 0, flush_id 0 and stall_cnt 0; combinational outputs follow their inputs, and reset asserted mid-FREEZE drops any pending flush.

Verification
REQ-040 FWD_EN=1, exe: wreg=1, m2reg=0, rd=3; rs=3, use_rs=1 -> fwda=01, pc_en=1, stall_cnt unchanged.
REQ-041 FWD_EN=1, exe: load, rd=5; rt=5, use_rt=1 -> one cycle of pc_en=0, id_bubble=1, stall_cnt+1; next cycle with mem: load, rd=5 -> fwdb=11.
REQ-042 FWD_EN=0, exe: ALU op, rd=4, then mem: rd=4; rs=4 -> two stall cycles, fwda=00 throughout.
REQ-043 branch_taken=1 and mem_busy=1 in the same cycle, busy for 3 cycles -> freeze=1 for 3 cycles, flush_id=0 during them, flush_id=1 for exactly one cycle after busy drops.
REQ-044 rd=0 with wreg=1 matching rs=0 -> fwda=00, no stall; CW=4 with 20 stalls -> stall_cnt=15; clr_cnt with a stall in the same cycle -> stall_cnt=0.
REQ-045 Clrn pulsed low in FREEZE with pend_br=1 -> state RUN, flush_id never asserted.
